delay_line_prog: RTL and testbench
==================================

Name: delay_line_prog

Overview:
- Programmable-depth delay buffer, successor to the fixed fill-then-shift delay fifo. Delays a BITS-wide sample stream by a runtime-selectable number of enabled cycles, 1..MAX_DEPTH.
- Uses a circular buffer with write pointer and derived read pointer; nothing shifts.
- Adds an output-valid flag, synchronous flush and run-time delay reprogramming.
- Sits on the MMIO-driven datapath between the CSR block (which supplies delay and control) and downstream consumers.

Parameters:
- MAX_DEPTH, 8, storage entries and maximum delay; power of two, >= 2.
- BITS, 64, sample width.
- DEF_DELAY, 8, delay loaded at reset; 1..MAX_DEPTH.
- DW, $clog2(MAX_DEPTH+1), width of delay fields (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  advance: write d and step pointer this cycle.
- clr  in  1  synchronous flush of valid history.
- cfg_load  in  1  latch cfg_delay as new delay.
- cfg_delay  in  DW  requested delay in enabled cycles.
- d  in  BITS  input sample.
- q  out  BITS  delayed sample; forced 0 when q_valid=0.
- q_valid  out  1  q holds a real sample.
- delay_cur  out  DW  currently active delay (clamped).

Behaviour:
- Reset (async, rst_n=0):
  - wr_ptr=0, fill=0, delay_r=DEF_DELAY.
  - q=0, q_valid=0, delay_cur=DEF_DELAY.
  - Storage array is not reset; masking makes it unobservable.
- Clamp: eff = (cfg_delay==0) ? 1 : (cfg_delay>MAX_DEPTH) ? MAX_DEPTH : cfg_delay. delay_cur=delay_r always.
- Enabled write (en=1, clr=0):
  - mem[wr_ptr] <= d.
  - wr_ptr <= wr_ptr+1, wrapping mod MAX_DEPTH.
  - fill <= min(fill+1, MAX_DEPTH).
- en=0: storage, pointers and fill hold; q and q_valid are stable.
- Read: rd_ptr = (wr_ptr - delay_r) mod MAX_DEPTH, combinational.
  - q = q_valid ? mem[rd_ptr] : 0.
  - q_valid = (fill >= delay_r).
  - After the k-th enabled write (k counted from 1), q = sample k-delay_r+1.
  - delay_r=1: q is the most recently written sample, the cycle after its en.
- Latency: a sample written on en #k appears on q after en #(k+delay_r-1) completes, once q_valid=1.
- cfg_load=1 (clr=0):
  - delay_r <= eff(cfg_delay).
  - fill <= en ? 1 : 0. History is invalidated, so a new delay never exposes stale samples.
  - If en=1, the write still occurs; wr_ptr is not reset.
- clr=1: has top priority.
  - fill <= 0; en and cfg_load are ignored that cycle (no write, no delay change).
  - q_valid drops the following cycle.
- Wrap-around: wr_ptr wraps silently; when fill saturates at MAX_DEPTH the oldest entry is overwritten, which is correct delay-line behaviour. No overflow or underflow flags exist.
- Boundary checks:
  - delay_r=MAX_DEPTH: rd_ptr==wr_ptr. The oldest entry is read before being overwritten on the next en; the read must see the pre-write value.
  - fill==delay_r-1 plus en: q_valid rises the next cycle with the first sample.
- Reset mid-operation: immediate return to reset state; the previous delay is lost (DEF_DELAY is restored).

Test Plan:
- Reset, DEF_DELAY=8, en=1 continuously, d=1,2,3,…
  - -> q_valid=0 and q=0 for the first 7 writes.
  - -> after write #8, q=1, q_valid=1; thereafter q increments by 1 per cycle.
- cfg_load with cfg_delay=1, then en with d=0xA5 then 0x5A
  - -> q=0xA5 after first write, 0x5A after second, q_valid=1 throughout.
- cfg_delay=0 -> delay_cur=1. cfg_delay=15 (MAX_DEPTH=8) -> delay_cur=8.
- Delay 3, stream d=10..20 with en toggling 1,0,1,0
  - -> q changes only after enabled cycles.
  - -> sequence 10,11,12,… starting after the 3rd enabled write; no duplicates or skips.
- Steady stream at delay 4, pulse cfg_load with cfg_delay=2 and en=1 simultaneously
  - -> q_valid=0 for one cycle, then q equals the sample written one write before the latest.
  - -> stale pre-load data never appears.
- Running stream: assert clr together with en and cfg_load (cfg_delay=5)
  - -> no write, delay_cur unchanged, q_valid=0 next cycle.
  - -> also assert rst_n=0 asynchronously mid-stream -> q=0, q_valid=0, delay_cur=DEF_DELAY immediately.

Source files
------------

// File: rtl/delay_line_prog_if.sv
// Sample/control bundle between the CSR-driven datapath and the programmable delay line.
// The master drives samples and configuration; the slave returns the delayed stream.
interface delay_line_prog_if #(
  parameter int BITS = 64,
  parameter int DW   = 4
);
  logic            en;
  logic            clr;
  logic            cfg_load;
  logic [DW-1:0]   cfg_delay;
  logic [BITS-1:0] d;
  logic [BITS-1:0] q;
  logic            q_valid;
  logic [DW-1:0]   delay_cur;

  modport master (
    output en, clr, cfg_load, cfg_delay, d,
    input  q, q_valid, delay_cur
  );

  modport slave (
    input  en, clr, cfg_load, cfg_delay, d,
    output q, q_valid, delay_cur
  );
endinterface

// File: rtl/delay_line_prog.sv
// Programmable-depth delay line: a circular buffer whose read pointer trails the write
// pointer by the active delay; a fill count masks entries not yet written since the last flush.
module delay_line_prog #(
  parameter int MAX_DEPTH = 8,
  parameter int BITS      = 64,
  parameter int DEF_DELAY = 8,
  parameter int DW        = $clog2(MAX_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  delay_line_prog_if.slave  bus
);
  localparam int AW = $clog2(MAX_DEPTH);

  logic [BITS-1:0] mem [MAX_DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [DW-1:0]   fill_r;
  logic [DW-1:0]   delay_r;
  logic [AW-1:0]   rd_ptr_s;
  logic            q_valid_s;
  logic [BITS-1:0] q_s;
  logic            wr_s;

  function automatic logic [DW-1:0] clamp_delay(input logic [DW-1:0] req);
    logic [DW-1:0] res;
    if (req == {DW{1'b0}}) begin
      res = DW'(1);
    end else if (req > DW'(MAX_DEPTH)) begin
      res = DW'(MAX_DEPTH);
    end else begin
      res = req;
    end
    return res;
  endfunction

  assign wr_s = bus.en && !bus.clr;

  // Sample storage; not reset because the fill count hides unwritten entries.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem[wr_ptr_r] <= bus.d;
    end
  end

  // Pointer, fill and delay state; clr outranks both writes and reprogramming.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      fill_r   <= {DW{1'b0}};
      delay_r  <= DW'(DEF_DELAY);
    end else if (bus.clr) begin
      fill_r   <= {DW{1'b0}};
    end else begin
      if (bus.en) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (bus.cfg_load) begin
        // A new delay invalidates history so stale samples never surface.
        delay_r <= clamp_delay(bus.cfg_delay);
        fill_r  <= bus.en ? DW'(1) : {DW{1'b0}};
      end else if (bus.en && (fill_r != DW'(MAX_DEPTH))) begin
        fill_r  <= fill_r + DW'(1);
      end else begin
        fill_r  <= fill_r;
      end
    end
  end

  // Read side: at delay MAX_DEPTH rd_ptr equals wr_ptr and sees the pre-write value.
  always_comb begin
    rd_ptr_s  = wr_ptr_r - delay_r[AW-1:0];
    q_valid_s = (fill_r >= delay_r);
    if (q_valid_s) begin
      q_s = mem[rd_ptr_s];
    end else begin
      q_s = {BITS{1'b0}};
    end
  end

  assign bus.q         = q_s;
  assign bus.q_valid   = q_valid_s;
  assign bus.delay_cur = delay_r;
endmodule

// File: tb/tb_delay_line_prog.sv
// Self-checking bench for delay_line_prog: directed scenarios plus random traffic,
// compared against a queue-based model of the valid sample history.
module tb_delay_line_prog;
  localparam int MAX_DEPTH = 8;
  localparam int BITS      = 64;
  localparam int DEF_DELAY = 8;
  localparam int DW        = $clog2(MAX_DEPTH + 1);

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [BITS-1:0] hist[$];
  int              m_delay;

  delay_line_prog_if #(.BITS(BITS), .DW(DW)) bus ();

  delay_line_prog #(
    .MAX_DEPTH(MAX_DEPTH),
    .BITS(BITS),
    .DEF_DELAY(DEF_DELAY)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int eff(input int req);
    if (req == 0) return 1;
    if (req > MAX_DEPTH) return MAX_DEPTH;
    return req;
  endfunction

  task automatic check(input string tag, input logic [BITS-1:0] obs, input logic [BITS-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic            v;
    logic [BITS-1:0] eq;
    v  = (hist.size() >= m_delay);
    eq = v ? hist[hist.size() - m_delay] : {BITS{1'b0}};
    check({tag, "_valid"}, {{(BITS-1){1'b0}}, bus.q_valid}, {{(BITS-1){1'b0}}, v});
    check({tag, "_q"}, bus.q, eq);
    check({tag, "_delay"}, {{(BITS-DW){1'b0}}, bus.delay_cur}, BITS'(m_delay));
  endtask

  // One clock: drive inputs, update the model at the edge, check 1 time unit later.
  task automatic step(input logic e, input logic c, input logic l,
                      input int cd, input logic [BITS-1:0] dd, input string tag);
    bus.en        = e;
    bus.clr       = c;
    bus.cfg_load  = l;
    bus.cfg_delay = DW'(cd);
    bus.d         = dd;
    @(posedge clk);
    if (c) begin
      hist.delete();
    end else begin
      if (l) begin
        m_delay = eff(cd);
        hist.delete();
      end
      if (e) begin
        hist.push_back(dd);
        if (hist.size() > MAX_DEPTH) void'(hist.pop_front());
      end
    end
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    hist.delete();
    m_delay = DEF_DELAY;
    #12;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.en = 1'b0; bus.clr = 1'b0; bus.cfg_load = 1'b0;
    bus.cfg_delay = '0; bus.d = '0;
    do_reset();
    check_model("reset");
    check("reset_delay_def", {{(BITS-DW){1'b0}}, bus.delay_cur}, 64'd8);

    // Default delay 8, continuous stream 1,2,3,...
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 1'b0, 1'b0, 0, BITS'(i), "def_stream");
      if (i == 7) check("def_w7_valid", {63'd0, bus.q_valid}, 64'd0);
      if (i == 8) check("def_w8_q", bus.q, 64'd1);
    end

    // Delay 1 with 0xA5 then 0x5A
    step(1'b0, 1'b0, 1'b1, 1, 64'd0, "load1");
    step(1'b1, 1'b0, 1'b0, 0, 64'hA5, "d1_a5");
    check("d1_a5_exact", bus.q, 64'hA5);
    step(1'b1, 1'b0, 1'b0, 0, 64'h5A, "d1_5a");
    check("d1_5a_exact", bus.q, 64'h5A);

    // Clamp boundaries
    step(1'b0, 1'b0, 1'b1, 0, 64'd0, "clamp0");
    check("clamp0_exact", {{(BITS-DW){1'b0}}, bus.delay_cur}, 64'd1);
    step(1'b0, 1'b0, 1'b1, 15, 64'd0, "clamp15");
    check("clamp15_exact", {{(BITS-DW){1'b0}}, bus.delay_cur}, 64'd8);
    // Full-depth delay exercises rd_ptr == wr_ptr across wrap
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 0, BITS'(100 + i), "full_depth");

    // Delay 3, en toggling
    step(1'b0, 1'b0, 1'b1, 3, 64'd0, "load3");
    for (int i = 0; i < 22; i++) step(i[0] == 1'b0, 1'b0, 1'b0, 0, BITS'(10 + i / 2), "toggle");

    // Delay 4 steady, then reload to 2 together with en
    step(1'b0, 1'b0, 1'b1, 4, 64'd0, "load4");
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 0, BITS'(200 + i), "d4_stream");
    step(1'b1, 1'b0, 1'b1, 2, 64'd300, "reload2");
    check("reload2_invalid", {63'd0, bus.q_valid}, 64'd0);
    step(1'b1, 1'b0, 1'b0, 0, 64'd301, "after_reload");
    check("after_reload_q", bus.q, 64'd300);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 31) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 15), {$urandom, $urandom}, "rand");
    end

    // clr beats en and cfg_load
    step(1'b0, 1'b0, 1'b1, 3, 64'd0, "load3b");
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 0, BITS'(500 + i), "pre_clr");
    step(1'b1, 1'b1, 1'b1, 5, 64'd999, "clr");
    check("clr_valid", {63'd0, bus.q_valid}, 64'd0);
    check("clr_delay", {{(BITS-DW){1'b0}}, bus.delay_cur}, 64'd3);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 0, BITS'(600 + i), "post_clr");

    // Asynchronous reset mid-stream
    bus.en = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_q", bus.q, 64'd0);
    check("arst_valid", {63'd0, bus.q_valid}, 64'd0);
    check("arst_delay", {{(BITS-DW){1'b0}}, bus.delay_cur}, 64'd8);
    bus.en = 1'b0;
    do_reset();
    check_model("post_arst");
    for (int i = 1; i <= 10; i++) step(1'b1, 1'b0, 1'b0, 0, BITS'(i), "post_arst_stream");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
